regfile_result_checker: RTL and testbench

Synthesizable, parametrised self-checker for the RISC-V pipeline. It snoops the register-file writeback port and keeps a shadow architectural register file. It holds a golden image loaded before the run. On halt or timeout it sequentially compares shadow against golden and reports pass/fail counts and the first mismatch. It sits beside the pipeline core in simulation and FPGA bring-up.

---
 rtl/regfile_result_checker_if.sv | 44 ++++
 rtl/regfile_result_checker.sv | 168 ++++++++++++++++
 tb/tb_regfile_result_checker.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_result_checker_if.sv
// regfile_result_checker_if: golden-load, run-control, writeback-snoop and
// result-report signals shared between the pipeline harness and the checker.
interface regfile_result_checker_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);

  // Golden image load
  logic            gold_we;
  logic [AW-1:0]   gold_addr;
  logic [XLEN-1:0] gold_data;

  // Run control and writeback snoop
  logic            start;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            halt;

  // Results
  logic            busy;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [CW-1:0]   pass_count;
  logic [CW-1:0]   fail_count;
  logic            first_fail_valid;
  logic [AW-1:0]   first_fail_idx;
  logic [31:0]     cycle_count;

  modport master (
    output gold_we, gold_addr, gold_data, start, wb_en, wb_addr, wb_data, halt,
    input  busy, done, pass, timeout, pass_count, fail_count,
           first_fail_valid, first_fail_idx, cycle_count
  );

  modport slave (
    input  gold_we, gold_addr, gold_data, start, wb_en, wb_addr, wb_data, halt,
    output busy, done, pass, timeout, pass_count, fail_count,
           first_fail_valid, first_fail_idx, cycle_count
  );
endinterface

// File: rtl/regfile_result_checker.sv
// regfile_result_checker: snoops register-file writebacks into a shadow
// register file, then on halt (after a drain window) or timeout walks the
// shadow against a preloaded golden image one register per cycle.
// Optional build macro RFCHK_WRITTEN_ONLY_EN: only registers written during
// the run (plus x0) take part in the comparison.
module regfile_result_checker #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_result_checker_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW:0]   NUM_REGS_W   = (AW + 1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX     = AW'(NUM_REGS - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_shadow [NUM_REGS];
  logic [XLEN-1:0] r_golden [NUM_REGS];
  logic [DW-1:0]   r_drain_cnt;
  logic [AW-1:0]   r_idx;
  logic [CW-1:0]   r_pass_count;
  logic [CW-1:0]   r_fail_count;
  logic            r_first_fail_valid;
  logic [AW-1:0]   r_first_fail_idx;
  logic            r_timeout;
  logic [31:0]     r_cycle_count;
`ifdef RFCHK_WRITTEN_ONLY_EN
  logic [NUM_REGS-1:0] r_written;
`endif

  logic w_run_entry;
  logic w_wb_accept;
  logic w_gold_accept;
  logic w_cmp_en;
  logic w_match;

  // Qualify handshakes against the current state and form the compare result.
  // NOTE: every signal is assigned on every pass through the block, so no latch is inferred.
  always_comb begin
    w_run_entry   = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    w_wb_accept   = ((r_state == S_RUN) || (r_state == S_DRAIN)) && bus.wb_en &&
                    (bus.wb_addr != '0) && ({1'b0, bus.wb_addr} < NUM_REGS_W);
    w_gold_accept = (r_state == S_IDLE) && bus.gold_we &&
                    ({1'b0, bus.gold_addr} < NUM_REGS_W);
    w_match       = (r_shadow[r_idx] == r_golden[r_idx]);
`ifdef RFCHK_WRITTEN_ONLY_EN
    w_cmp_en      = (r_idx == '0) || r_written[r_idx];
`else
    w_cmp_en      = 1'b1;
`endif
  end

  // Golden image loading, shadow capture, and shadow clear on run entry.
  // NOTE: both arrays are reset element by element because the golden image must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_golden[i] <= '0;
      end
`ifdef RFCHK_WRITTEN_ONLY_EN
      r_written <= '0;
`endif
    end else begin
      if (w_gold_accept) r_golden[bus.gold_addr] <= bus.gold_data;
      if (w_run_entry) begin
        for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
`ifdef RFCHK_WRITTEN_ONLY_EN
        r_written <= '0;
`endif
      end else if (w_wb_accept) begin
        r_shadow[bus.wb_addr] <= bus.wb_data;
`ifdef RFCHK_WRITTEN_ONLY_EN
        r_written[bus.wb_addr] <= 1'b1;
`endif
      end
    end
  end

  // Run/drain/check sequencing with pass/fail accounting.
  // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_drain_cnt        <= '0;
      r_idx              <= '0;
      r_pass_count       <= '0;
      r_fail_count       <= '0;
      r_first_fail_valid <= 1'b0;
      r_first_fail_idx   <= '0;
      r_timeout          <= 1'b0;
      r_cycle_count      <= '0;
    end else if (w_run_entry) begin
      r_state            <= S_RUN;
      r_drain_cnt        <= '0;
      r_idx              <= '0;
      r_pass_count       <= '0;
      r_fail_count       <= '0;
      r_first_fail_valid <= 1'b0;
      r_first_fail_idx   <= '0;
      r_timeout          <= 1'b0;
      r_cycle_count      <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_cycle_count <= r_cycle_count + 32'd1;
          // halt takes priority over a coincident timeout
          if (bus.halt) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DW'(DRAIN_CYCLES);
          end else if (r_cycle_count == TIMEOUT_LAST) begin
            r_state   <= S_CHECK;
            r_timeout <= 1'b1;
            r_idx     <= '0;
          end
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - DW'(1);
          if (r_drain_cnt <= DW'(1)) begin
            r_state <= S_CHECK;
            r_idx   <= '0;
          end
        end
        S_CHECK: begin
          if (w_cmp_en) begin
            if (w_match) begin
              r_pass_count <= r_pass_count + CW'(1);
            end else begin
              r_fail_count <= r_fail_count + CW'(1);
              if (!r_first_fail_valid) begin
                r_first_fail_valid <= 1'b1;
                r_first_fail_idx   <= r_idx;
              end
            end
          end
          if (r_idx == LAST_IDX) r_state <= S_DONE;
          else                   r_idx   <= r_idx + AW'(1);
        end
        S_IDLE, S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy             = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_CHECK);
  assign bus.done             = (r_state == S_DONE);
  assign bus.pass             = (r_state == S_DONE) && (r_fail_count == '0) && !r_timeout;
  assign bus.timeout          = r_timeout;
  assign bus.pass_count       = r_pass_count;
  assign bus.fail_count       = r_fail_count;
  assign bus.first_fail_valid = r_first_fail_valid;
  assign bus.first_fail_idx   = r_first_fail_idx;
  assign bus.cycle_count      = r_cycle_count;
endmodule

// File: tb/tb_regfile_result_checker.sv
// tb_regfile_result_checker: directed scenarios with a result scoreboard;
// expected results come from a bench-side golden/shadow model.
module tb_regfile_result_checker;
  localparam int XLEN           = 32;
  localparam int NUM_REGS       = 32;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int DRAIN_CYCLES   = 4;
  localparam int AW             = $clog2(NUM_REGS);
  localparam int HALT_LAT       = 1 + DRAIN_CYCLES + NUM_REGS;

  typedef struct {
    logic pass;
    logic timeout;
    int   pass_count;
    int   fail_count;
    logic ffv;
    int   ffi;
    int   cycles;
    int   latency;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [XLEN-1:0] m_gold   [NUM_REGS];
  logic [XLEN-1:0] m_shadow [NUM_REGS];
  logic            m_in_run;
  int              m_run_ticks;
  int              lat;

  regfile_result_checker_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) bus ();

  regfile_result_checker #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_in_run) m_run_ticks++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_gold[i]   = '0;
      m_shadow[i] = '0;
    end
  endtask

  task automatic do_reset();
    m_in_run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/busy"},       32'(bus.busy), 32'd0);
    check({tag, "/done"},       32'(bus.done), 32'd0);
    check({tag, "/pass"},       32'(bus.pass), 32'd0);
    check({tag, "/timeout"},    32'(bus.timeout), 32'd0);
    check({tag, "/pass_count"}, 32'(bus.pass_count), 32'd0);
    check({tag, "/fail_count"}, 32'(bus.fail_count), 32'd0);
    check({tag, "/ffv"},        32'(bus.first_fail_valid), 32'd0);
    check({tag, "/cycles"},     bus.cycle_count, 32'd0);
  endtask

  task automatic gold_write(input int a, input logic [XLEN-1:0] d);
    bus.gold_we = 1'b1; bus.gold_addr = AW'(a); bus.gold_data = d;
    tick();
    bus.gold_we = 1'b0;
    m_gold[a] = d;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_in_run = 1'b1;
    m_run_ticks = 0;
    for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = '0;
  endtask

  task automatic wb(input int a, input logic [XLEN-1:0] d, input bit capture);
    bus.wb_en = 1'b1; bus.wb_addr = AW'(a); bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
    if (capture && a != 0) m_shadow[a] = d;
  endtask

  task automatic halt_run();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    m_in_run = 1'b0;
    lat = 1;
  endtask

  task automatic push_expect(input logic tmo, input int cycles, input int latency);
    exp_t e;
    e.pass_count = 0; e.fail_count = 0; e.ffv = 1'b0; e.ffi = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (m_shadow[i] === m_gold[i]) e.pass_count++;
      else begin
        e.fail_count++;
        if (!e.ffv) begin e.ffv = 1'b1; e.ffi = i; end
      end
    end
    e.timeout = tmo;
    e.pass    = (e.fail_count == 0) && !tmo;
    e.cycles  = cycles;
    e.latency = latency;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string tag);
    exp_t e;
    while (bus.done !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    check({tag, "/done"}, 32'(bus.done), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "/latency"},    32'(lat), 32'(e.latency));
      check({tag, "/pass"},       32'(bus.pass), 32'(e.pass));
      check({tag, "/timeout"},    32'(bus.timeout), 32'(e.timeout));
      check({tag, "/pass_count"}, 32'(bus.pass_count), 32'(e.pass_count));
      check({tag, "/fail_count"}, 32'(bus.fail_count), 32'(e.fail_count));
      check({tag, "/ffv"},        32'(bus.first_fail_valid), 32'(e.ffv));
      check({tag, "/ffi"},        32'(bus.first_fail_idx), 32'(e.ffi));
      check({tag, "/cycles"},     bus.cycle_count, 32'(e.cycles));
      check({tag, "/busy"},       32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.gold_we = 1'b0; bus.gold_addr = '0; bus.gold_data = '0;
    bus.start = 1'b0; bus.halt = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    m_in_run = 1'b0; m_run_ticks = 0; lat = 0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    check_cleared("reset");

    // Basic pass: golden x1..x3, matching writebacks
    gold_write(1, 32'd1); gold_write(2, 32'd2); gold_write(3, 32'd3);
    start_run();
    check("t1/busy_run", 32'(bus.busy), 32'd1);
    wb(1, 32'd1, 1'b1); wb(2, 32'd2, 1'b1); wb(3, 32'd3, 1'b1);
    halt_run();
    push_expect(1'b0, m_run_ticks, HALT_LAT);
    wait_done(200, "t1");
    repeat (3) tick();
    check("t1/done_held",  32'(bus.done), 32'd1);
    check("t1/count_held", 32'(bus.pass_count), 32'(NUM_REGS));

    // Rerun from DONE: counts clear, golden retained
    start_run();
    check("t6a/cleared_count", 32'(bus.pass_count), 32'd0);
    check("t6a/cleared_done",  32'(bus.done), 32'd0);
    check("t6a/busy",          32'(bus.busy), 32'd1);
    wb(1, 32'd1, 1'b1); wb(2, 32'd2, 1'b1); wb(3, 32'd3, 1'b1);
    halt_run();
    push_expect(1'b0, m_run_ticks, HALT_LAT);
    wait_done(200, "t6a");

    // Mismatches; golden write and start during RUN are ignored
    do_reset();
    gold_write(5, 32'h5);
    start_run();
    bus.gold_we = 1'b1; bus.gold_addr = AW'(5); bus.gold_data = 32'hDEADBEEF;
    tick();
    bus.gold_we = 1'b0;
    wb(5, 32'hDEADBEEF, 1'b1);
    bus.start = 1'b1;
    wb(9, 32'h1, 1'b1);
    bus.start = 1'b0;
    halt_run();
    push_expect(1'b0, m_run_ticks, HALT_LAT);
    wait_done(200, "t2");

    // x0 writes are dropped
    do_reset();
    start_run();
    wb(0, 32'hFFFFFFFF, 1'b1);
    halt_run();
    push_expect(1'b0, m_run_ticks, HALT_LAT);
    wait_done(200, "t3");

    // Drain capture; halt in DRAIN, writeback and start in CHECK ignored
    do_reset();
    gold_write(7, 32'h77);
    start_run();
    halt_run();
    tick(); lat++;
    wb(7, 32'h77, 1'b1); lat++;
    bus.halt = 1'b1;
    tick(); lat++;
    bus.halt = 1'b0;
    tick(); lat++;
    bus.start = 1'b1;
    wb(8, 32'h88, 1'b0); lat++;
    bus.start = 1'b0;
    check("t5/busy_check", 32'(bus.busy), 32'd1);
    push_expect(1'b0, m_run_ticks, HALT_LAT);
    wait_done(200, "t5");

    // Reset mid-CHECK aborts and clears the golden image
    start_run();
    wb(3, 32'h3, 1'b1);
    halt_run();
    repeat (14) tick();
    check("t6b/in_check", 32'(bus.busy), 32'd1);
    do_reset();
    check_cleared("t6b_rst");
    start_run();
    halt_run();
    push_expect(1'b0, m_run_ticks, HALT_LAT);
    wait_done(200, "t6b");

    // Timeout: no halt, all registers match, still not a pass
    start_run();
    m_in_run = 1'b0;
    lat = 1;
    push_expect(1'b1, TIMEOUT_CYCLES, 1 + TIMEOUT_CYCLES + NUM_REGS);
    wait_done(TIMEOUT_CYCLES + NUM_REGS + 100, "t4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
